// File: rtl/booth_mult_seq.sv
// Sequential 32x32 signed radix-2 Booth multiplier: 32 iterations, 1-cycle ready strobe.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips straight to DONE (latency 1).
module booth_mult_seq (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic [1:0]  dbg_state
);

  // Handshake: ctrl_MULT is a start pulse sampled every edge and always wins
  // (it restarts an operation in progress). data_resultRDY is high for exactly
  // one cycle per completed operation; result/exception hold until next start.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [64:0] p;      // {A, Q, q_m1}
  logic [31:0] m;
  logic [5:0]  cnt;

  logic [32:0] m_ext;
  logic [32:0] addend;
  logic [32:0] sum;
  logic        start_zero;

`ifdef MULT_ZERO_BYPASS_EN
  assign start_zero = (data_operandA == 32'd0) || (data_operandB == 32'd0);
`else
  assign start_zero = 1'b0;
`endif

  // 33-bit arithmetic keeps the true sign, so -M is exact for M = 0x80000000.
  always_comb begin
    m_ext  = {m[31], m};
    addend = '0;
    case (p[1:0])
      2'b01:   addend = m_ext;
      2'b10:   addend = ~m_ext + 33'd1;
      default: addend = '0;
    endcase
    sum = {p[64], p[64:33]} + addend;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state <= IDLE;
      p     <= '0;
      m     <= '0;
      cnt   <= '0;
    end else if (ctrl_MULT) begin
      m   <= data_operandA;
      cnt <= '0;
      if (start_zero) begin
        p     <= '0;
        state <= DONE;
      end else begin
        p     <= {32'd0, data_operandB, 1'b0};
        state <= RUN;
      end
    end else begin
      case (state)
        RUN: begin
          p   <= {sum, p[32:1]};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign data_result    = p[32:1];
  assign data_exception = (|p[64:32]) && !(&p[64:32]);
  assign data_resultRDY = (state == DONE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed corner cases, abort, reset
// and randomized operands checked against a plain-arithmetic product model.
module tb_booth_mult_seq;

  logic        clock;
  logic        ctrl_reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [1:0]  dbg_state;

  int compared   = 0;
  int mismatched = 0;

  // {latency[5:0], exception, result[31:0]}
  logic [38:0] exp_q[$];

  booth_mult_seq dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [38:0] model(input logic [31:0] a, input logic [31:0] b);
    longint prod;
    logic [31:0] res;
    logic exc;
    logic [5:0] lat;
    prod = longint'($signed(a)) * longint'($signed(b));
    res  = prod[31:0];
    exc  = (prod > 64'sd2147483647) || (prod < -64'sd2147483648);
    lat  = 6'd32;
`ifdef MULT_ZERO_BYPASS_EN
    if (a == 32'd0 || b == 32'd0) lat = 6'd1;
`endif
    return {lat, exc, res};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(model(a, b));
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic finish_op(input string tag);
    int cyc;
    logic [38:0] e;
    wait_rdy(cyc);
    e = exp_q.pop_front();
    check({tag, "_latency"}, 64'(cyc), 64'(e[38:33]));
    check({tag, "_result"}, 64'(data_result), 64'(e[31:0]));
    check({tag, "_exception"}, 64'(data_exception), 64'(e[32]));
  endtask

  task automatic hold_check(input string tag);
    logic [31:0] r;
    logic x;
    r = data_result;
    x = data_exception;
    @(posedge clock);
    #1;
    check({tag, "_rdy_drop"}, 64'(data_resultRDY), 64'd0);
    check({tag, "_hold"}, {31'd0, x, r}, {31'd0, data_exception, data_result});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int seen;
    ctrl_reset_n  = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", {31'd0, data_resultRDY, data_exception, data_result}, 64'd0);
    ctrl_reset_n = 1'b1;
    @(posedge clock);
    #1;

    // directed products
    start_op(32'd3, 32'd5);                   finish_op("3x5");       hold_check("3x5");
    start_op(32'hFFFFFFF9, 32'd6);            finish_op("m7x6");      hold_check("m7x6");
    start_op(32'h7FFFFFFF, 32'd2);            finish_op("maxx2");     hold_check("maxx2");
    start_op(32'h80000000, 32'hFFFFFFFF);     finish_op("minxm1");    hold_check("minxm1");
    start_op(32'h80000000, 32'h80000000);     finish_op("minxmin");   hold_check("minxmin");
    start_op(32'd0, 32'h1234);                finish_op("0x1234");    hold_check("0x1234");
    start_op(32'h1234, 32'd0);                finish_op("1234x0");    hold_check("1234x0");

    // abort: 9x9 restarted by 4 x -2 ten cycles later, no strobe for the first
    start_op(32'd9, 32'd9);
    void'(exp_q.pop_back());
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    check("abort_no_strobe", 64'(seen), 64'd0);
    start_op(32'd4, 32'hFFFFFFFE);            finish_op("abort_4xm2"); hold_check("abort_4xm2");

    // reset mid-operation at cycle 15, then release with ctrl_MULT already high
    start_op(32'd100, 32'd100);
    void'(exp_q.pop_back());
    repeat (14) @(posedge clock);
    #3;
    ctrl_reset_n = 1'b0;
    #1;
    check("midreset_outputs", {31'd0, data_resultRDY, data_exception, data_result}, 64'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    check("midreset_no_strobe", 64'(seen), 64'd0);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd100;
    exp_q.push_back(model(32'd100, 32'd100));
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    finish_op("after_reset_100x100");
    check("after_reset_value", 64'(data_result), 64'h2710);

    // randomized operands; every other op starts back-to-back in the DONE cycle
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'd0;
        2: a = $urandom_range(0, 15) - 8;
        3: b = 32'h7FFFFFFF;
        default: ;
      endcase
      start_op(a, b);
      finish_op($sformatf("rand%0d", n));
      if (n[0]) hold_check($sformatf("rand%0d", n));
    end
    hold_check("final");

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
